// File: rtl/spinner_arb.sv
// spinner_arb: three requesters (spinner 1, spinner 2, step buttons) share one
// 10-bit position accumulator through a round-robin arbiter, one grant per clock.
// Optional build macro SPINNER_CLAMP_EN: saturate the accumulator to 0..1023
// instead of letting it wrap modulo 1024.

module spinner_arb #(
  parameter int INC_NORMAL  = 20,
  parameter int INC_FAST    = 27,
  parameter int INC_SPINNER = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [8:0] spin1_in,
  input  logic [8:0] spin2_in,
  input  logic       minus,
  input  logic       plus,
  input  logic       fast,
  input  logic       strobe,
  output logic [7:0] spin_out,
  output logic       busy
);

  // Requester identifiers double as the round-robin "last granted" pointer.
  typedef enum logic [1:0] {
    SRC_S1 = 2'd0,
    SRC_S2 = 2'd1,
    SRC_B  = 2'd2
  } src_e;

  // Edge-detect copies and the armed flag that suppresses events right after reset.
  logic       armed_q, armed_d;
  logic       spin1_tog_q, spin1_tog_d;
  logic       spin2_tog_q, spin2_tog_d;
  logic       strobe_q, strobe_d;

  // Per-requester hold registers and pending flags (index 0=S1, 1=S2, 2=B).
  logic signed [15:0] hold_q [0:2];
  logic signed [15:0] hold_d [0:2];
  logic [2:0]         pend_q, pend_d;

  // Shared accumulator and arbitration pointer.
  logic [9:0] acc_q, acc_d;
  src_e       last_q, last_d;

  // Event strobes and their deltas.
  logic [2:0]         ev;
  logic signed [15:0] delta [0:2];
  logic signed [15:0] b_inc;

  // Arbitration result.
  logic       grant_vld;
  src_e       grant_src;
  logic [2:0] grant_oh;

  // Saturating signed 16-bit add used when a new event lands on an unserved request.
  function automatic logic signed [15:0] sat_add(input logic signed [15:0] a,
                                                 input logic signed [15:0] b);
    logic signed [16:0] s;
    s = {a[15], a} + {b[15], b};
    if (s[16] != s[15]) begin
      return s[16] ? 16'sh8000 : 16'sh7fff;
    end
    return s[15:0];
  endfunction

  // Spinner deltas are the signed sample scaled by INC_SPINNER; button delta
  // picks the step size from fast and the sign from plus/minus.
  always_comb begin
    delta[0] = 16'(signed'(spin1_in[7:0]) * INC_SPINNER);
    delta[1] = 16'(signed'(spin2_in[7:0]) * INC_SPINNER);
    b_inc    = fast ? 16'(INC_FAST) : 16'(INC_NORMAL);
    delta[2] = plus ? b_inc : -b_inc;
  end

  // Events fire on a toggle of bit 8 or a strobe rising edge with exactly one
  // of plus/minus set, but only once the detectors have been armed.
  always_comb begin
    ev[0] = armed_q & (spin1_in[8] ^ spin1_tog_q);
    ev[1] = armed_q & (spin2_in[8] ^ spin2_tog_q);
    ev[2] = armed_q & strobe & ~strobe_q & (plus ^ minus);
  end

  // Round-robin grant: search starts with the requester after the last one served.
  always_comb begin
    grant_vld = 1'b0;
    grant_src = SRC_S1;
    unique case (last_q)
      SRC_S1: begin
        if (pend_q[1])      begin grant_vld = 1'b1; grant_src = SRC_S2; end
        else if (pend_q[2]) begin grant_vld = 1'b1; grant_src = SRC_B;  end
        else if (pend_q[0]) begin grant_vld = 1'b1; grant_src = SRC_S1; end
      end
      SRC_S2: begin
        if (pend_q[2])      begin grant_vld = 1'b1; grant_src = SRC_B;  end
        else if (pend_q[0]) begin grant_vld = 1'b1; grant_src = SRC_S1; end
        else if (pend_q[1]) begin grant_vld = 1'b1; grant_src = SRC_S2; end
      end
      default: begin
        if (pend_q[0])      begin grant_vld = 1'b1; grant_src = SRC_S1; end
        else if (pend_q[1]) begin grant_vld = 1'b1; grant_src = SRC_S2; end
        else if (pend_q[2]) begin grant_vld = 1'b1; grant_src = SRC_B;  end
      end
    endcase
    grant_oh = 3'b000;
    if (grant_vld) begin
      grant_oh[grant_src] = 1'b1;
    end
  end

  // Hold/pending update: a new event either starts a request, coalesces into an
  // unserved one, or replaces a value that is being consumed this very cycle.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      hold_d[i] = hold_q[i];
      pend_d[i] = pend_q[i];
      if (ev[i]) begin
        if (pend_q[i] && !grant_oh[i]) begin
          hold_d[i] = sat_add(hold_q[i], delta[i]);
        end else begin
          hold_d[i] = delta[i];
        end
        pend_d[i] = 1'b1;
      end else if (grant_oh[i]) begin
        pend_d[i] = 1'b0;
      end
    end
  end

`ifdef SPINNER_CLAMP_EN
  logic signed [15:0] grant_val;
  logic signed [16:0] acc_sum;

  // Clamped build: full-width signed sum, saturated to the accumulator range.
  always_comb begin
    unique case (grant_src)
      SRC_S1:  grant_val = hold_q[0];
      SRC_S2:  grant_val = hold_q[1];
      default: grant_val = hold_q[2];
    endcase
    acc_sum = $signed({7'b0, acc_q}) + $signed({grant_val[15], grant_val});
    acc_d   = acc_q;
    if (grant_vld) begin
      if (acc_sum < 0) begin
        acc_d = 10'd0;
      end else if (acc_sum > 17'sd1023) begin
        acc_d = 10'd1023;
      end else begin
        acc_d = acc_sum[9:0];
      end
    end
  end
`else
  logic [9:0] grant_lo;

  // Wrapping build: only the low ten bits of the delta matter modulo 1024.
  always_comb begin
    unique case (grant_src)
      SRC_S1:  grant_lo = hold_q[0][9:0];
      SRC_S2:  grant_lo = hold_q[1][9:0];
      default: grant_lo = hold_q[2][9:0];
    endcase
    acc_d = acc_q;
    if (grant_vld) begin
      acc_d = acc_q + grant_lo;
    end
  end
`endif

  // Next-state for the detectors and pointer; detectors simply track their inputs.
  always_comb begin
    armed_d     = 1'b1;
    spin1_tog_d = spin1_in[8];
    spin2_tog_d = spin2_in[8];
    strobe_d    = strobe;
    last_d      = grant_vld ? grant_src : last_q;
  end

  // All state; reset drops every request and points the arbiter at B so S1 leads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      armed_q     <= 1'b0;
      spin1_tog_q <= 1'b0;
      spin2_tog_q <= 1'b0;
      strobe_q    <= 1'b0;
      pend_q      <= 3'b000;
      acc_q       <= 10'd0;
      last_q      <= SRC_B;
      for (int i = 0; i < 3; i++) begin
        hold_q[i] <= 16'sd0;
      end
    end else begin
      armed_q     <= armed_d;
      spin1_tog_q <= spin1_tog_d;
      spin2_tog_q <= spin2_tog_d;
      strobe_q    <= strobe_d;
      pend_q      <= pend_d;
      acc_q       <= acc_d;
      last_q      <= last_d;
      for (int i = 0; i < 3; i++) begin
        hold_q[i] <= hold_d[i];
      end
    end
  end

  assign spin_out = acc_q[9:2];
  assign busy     = |pend_q;

endmodule

// File: tb/tb_spinner_arb.sv
// tb_spinner_arb: table-driven directed vectors for spinner_arb plus hand-written
// sequences for request coalescing and asynchronous reset with pending requests.
// Honours SPINNER_CLAMP_EN the same way as the design.

module tb_spinner_arb;

  logic       clk;
  logic       reset;
  logic [8:0] spin1_in;
  logic [8:0] spin2_in;
  logic       minus;
  logic       plus;
  logic       fast;
  logic       strobe;
  logic [7:0] spin_out;
  logic       busy;

  int vec_count;
  int miss_count;

  // One row: inputs applied before a rising edge, outputs expected just after it.
  typedef struct {
    logic       rst;
    logic [8:0] s1;
    logic [8:0] s2;
    logic [3:0] btn;
    logic [7:0] exp_out;
    logic       exp_busy;
  } vec_t;

  localparam int NV = 27;
  vec_t vecs [NV];

  spinner_arb #(
    .INC_NORMAL (20),
    .INC_FAST   (27),
    .INC_SPINNER(20)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .spin1_in(spin1_in),
    .spin2_in(spin2_in),
    .minus   (minus),
    .plus    (plus),
    .fast    (fast),
    .strobe  (strobe),
    .spin_out(spin_out),
    .busy    (busy)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic setVec(input int i, input logic rst, input logic [8:0] s1,
                        input logic [8:0] s2, input logic [3:0] btn,
                        input logic [7:0] eo, input logic eb);
    vecs[i].rst      = rst;
    vecs[i].s1       = s1;
    vecs[i].s2       = s2;
    vecs[i].btn      = btn;
    vecs[i].exp_out  = eo;
    vecs[i].exp_busy = eb;
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    reset    = v.rst;
    spin1_in = v.s1;
    spin2_in = v.s2;
    {plus, minus, fast, strobe} = v.btn;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] eo, input logic eb);
    vec_count++;
    if (spin_out !== eo || busy !== eb) begin
      miss_count++;
      $display("[TB] FAIL %s: spin_out=%0d busy=%b, expected spin_out=%0d busy=%b",
               name, spin_out, busy, eo, eb);
    end
  endtask

  task automatic resetDut();
    @(negedge clk);
    reset    = 1'b1;
    spin1_in = 9'h000;
    spin2_in = 9'h000;
    {plus, minus, fast, strobe} = 4'b0000;
    @(posedge clk);
    #1;
    checkOutput("reset", 8'd0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("arm", 8'd0, 1'b0);
  endtask

  initial begin
    vec_count  = 0;
    miss_count = 0;
    reset      = 1'b1;
    spin1_in   = 9'h000;
    spin2_in   = 9'h000;
    {plus, minus, fast, strobe} = 4'b0000;

    // btn = {plus, minus, fast, strobe}
    // single spinner step: +5 -> +100 -> spin_out 25 two edges later
    setVec( 0, 1, 9'h000, 9'h000, 4'b0000,   0, 0);
    setVec( 1, 0, 9'h000, 9'h000, 4'b0000,   0, 0);
    setVec( 2, 0, 9'h105, 9'h000, 4'b0000,   0, 1);
    setVec( 3, 0, 9'h105, 9'h000, 4'b0000,  25, 0);
    setVec( 4, 0, 9'h105, 9'h000, 4'b0000,  25, 0);
    // simultaneous S1 +5 and S2 -3 from zero: S1 first (acc 100), then S2 (acc 40)
    setVec( 5, 1, 9'h105, 9'h000, 4'b0000,   0, 0);
    setVec( 6, 0, 9'h105, 9'h000, 4'b0000,   0, 0);
    setVec( 7, 0, 9'h005, 9'h1FD, 4'b0000,   0, 1);
    setVec( 8, 0, 9'h005, 9'h1FD, 4'b0000,  25, 1);
    setVec( 9, 0, 9'h005, 9'h1FD, 4'b0000,  10, 0);
    setVec(10, 0, 9'h005, 9'h1FD, 4'b0000,  10, 0);
    // buttons: +27 fast, both pressed ignored, -20 normal -> acc 7
    setVec(11, 1, 9'h005, 9'h1FD, 4'b0000,   0, 0);
    setVec(12, 0, 9'h005, 9'h1FD, 4'b0000,   0, 0);
    setVec(13, 0, 9'h005, 9'h1FD, 4'b1011,   0, 1);
    setVec(14, 0, 9'h005, 9'h1FD, 4'b1011,   6, 0);
    setVec(15, 0, 9'h005, 9'h1FD, 4'b1100,   6, 0);
    setVec(16, 0, 9'h005, 9'h1FD, 4'b1101,   6, 0);
    setVec(17, 0, 9'h005, 9'h1FD, 4'b1101,   6, 0);
    setVec(18, 0, 9'h005, 9'h1FD, 4'b0100,   6, 0);
    setVec(19, 0, 9'h005, 9'h1FD, 4'b0101,   6, 1);
    setVec(20, 0, 9'h005, 9'h1FD, 4'b0101,   1, 0);
    // top of range: +51 -> acc 1020, then +1 -> clamp 1023 or wrap to 16
    setVec(21, 1, 9'h000, 9'h000, 4'b0000,   0, 0);
    setVec(22, 0, 9'h000, 9'h000, 4'b0000,   0, 0);
    setVec(23, 0, 9'h133, 9'h000, 4'b0000,   0, 1);
    setVec(24, 0, 9'h133, 9'h000, 4'b0000, 255, 0);
    setVec(25, 0, 9'h001, 9'h000, 4'b0000, 255, 1);
`ifdef SPINNER_CLAMP_EN
    setVec(26, 0, 9'h001, 9'h000, 4'b0000, 255, 0);
`else
    setVec(26, 0, 9'h001, 9'h000, 4'b0000,   4, 0);
`endif

    for (int i = 0; i < NV; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp_out, vecs[i].exp_busy);
    end

    // Coalescing: S1 toggles on three consecutive edges while S2 and B wait.
    // Grants run S1(20), S2(20), B(20), S1(40) -> acc 100.
    resetDut();
    @(negedge clk);
    spin1_in = 9'h101;
    spin2_in = 9'h101;
    plus     = 1'b1;
    strobe   = 1'b1;
    @(posedge clk); #1;
    checkOutput("coal_e1", 8'd0, 1'b1);
    @(negedge clk);
    spin1_in = 9'h001;
    @(posedge clk); #1;
    checkOutput("coal_e2", 8'd5, 1'b1);
    @(negedge clk);
    spin1_in = 9'h101;
    @(posedge clk); #1;
    checkOutput("coal_e3", 8'd10, 1'b1);
    @(posedge clk); #1;
    checkOutput("coal_e4", 8'd15, 1'b1);
    @(posedge clk); #1;
    checkOutput("coal_e5", 8'd25, 1'b0);

    // Asynchronous reset with all three pending; toggle bit held high through release.
    resetDut();
    @(negedge clk);
    spin1_in = 9'h105;
    @(posedge clk); #1;
    checkOutput("rst_load", 8'd0, 1'b1);
    @(posedge clk); #1;
    checkOutput("rst_acc", 8'd25, 1'b0);
    @(negedge clk);
    spin1_in = 9'h005;
    spin2_in = 9'h101;
    plus     = 1'b1;
    strobe   = 1'b1;
    @(posedge clk); #1;
    checkOutput("rst_allpend", 8'd25, 1'b1);
    @(negedge clk);
    reset    = 1'b1;
    spin1_in = 9'h105;
    #1;
    checkOutput("rst_async", 8'd0, 1'b0);
    @(posedge clk); #1;
    checkOutput("rst_hold", 8'd0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    checkOutput("rst_arm", 8'd0, 1'b0);
    @(posedge clk); #1;
    checkOutput("rst_noev1", 8'd0, 1'b0);
    @(posedge clk); #1;
    checkOutput("rst_noev2", 8'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
